// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment driver with per-frame digit snapshot and adjust-digit blink.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  dp,
  input  logic [2:0]  adj_sel,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic [3:0]  an
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] R_TC = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] B_TC = BW'(BLINK_DIV - 1);

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          blink_off_q, blink_off_d;
  logic [15:0]   snap_q, snap_d;
  logic [3:0]    dp_snap_q, dp_snap_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_n_q, dp_n_d;
  logic [3:0]    an_q, an_d;

  logic          r_tc, b_tc, blank, lz_blank;
  logic [3:0]    nib;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    r_tc = (rcnt_q == R_TC);
    b_tc = (bcnt_q == B_TC);

    rcnt_d      = r_tc ? '0 : rcnt_q + RW'(1);
    idx_d       = r_tc ? idx_q + 2'd1 : idx_q;
    bcnt_d      = b_tc ? '0 : bcnt_q + BW'(1);
    blink_off_d = b_tc ? ~blink_off_q : blink_off_q;

    // Snapshot only as the index wraps so a frame never mixes old and new digits
    snap_d    = snap_q;
    dp_snap_d = dp_snap_q;
    if (r_tc && idx_q == 2'd3) begin
      snap_d    = digits;
      dp_snap_d = dp;
    end

    lz_blank = 1'b0;
`ifdef SEG_LZ_BLANK_EN
    case (idx_q)
      2'd3:    lz_blank = (snap_q[15:12] == 4'h0) && !dp_snap_q[3];
      2'd2:    lz_blank = (snap_q[15:8] == 8'h00) && (dp_snap_q[3:2] == 2'b00);
      2'd1:    lz_blank = (snap_q[15:4] == 12'h000) && (dp_snap_q[3:1] == 3'b000);
      default: lz_blank = 1'b0;
    endcase
`endif

    nib   = snap_q[4*idx_q +: 4];
    blank = (blink_off_q && (adj_sel == {1'b0, idx_q})) || lz_blank;

    an_d   = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d  = blank ? 7'h7F : decode(nib);
    dp_n_d = blank ? 1'b1 : ~dp_snap_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q      <= '0;
      bcnt_q      <= '0;
      idx_q       <= 2'd0;
      blink_off_q <= 1'b0;
      snap_q      <= 16'h0000;
      dp_snap_q   <= 4'h0;
      an_q        <= 4'b1111;
      seg_q       <= 7'h7F;
      dp_n_q      <= 1'b1;
    end else begin
      rcnt_q      <= rcnt_d;
      bcnt_q      <= bcnt_d;
      idx_q       <= idx_d;
      blink_off_q <= blink_off_d;
      snap_q      <= snap_d;
      dp_snap_q   <= dp_snap_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_n_q      <= dp_n_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp_n = dp_n_q;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: cycle model feeding a scoreboard queue plus directed pattern checks.
module tb_seg_scan;

  localparam int RD = 4;
  localparam int BD = 32;

  logic        clk;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [2:0]  adj_sel;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;

  int n_tests = 0;
  int n_fail  = 0;

  seg_scan #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .digits(digits), .dp(dp), .adj_sel(adj_sel),
    .seg(seg), .dp_n(dp_n), .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
          7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction

  // reference model: expected {an, seg, dp_n} pushed each edge, popped at the next negedge
  logic [11:0] sb_q [$];
  int          m_rcnt, m_bcnt, m_idx;
  logic        m_boff;
  logic [15:0] m_snap;
  logic [3:0]  m_dps;

  always @(posedge clk) begin
    logic [11:0] e;
    logic        bl;
    if (rst) begin
      m_rcnt = 0; m_bcnt = 0; m_idx = 0; m_boff = 1'b0; m_snap = 16'h0; m_dps = 4'h0;
      e = {4'b1111, 7'h7F, 1'b1};
    end else begin
      bl = m_boff && (int'(adj_sel) == m_idx);
`ifdef SEG_LZ_BLANK_EN
      if (m_idx > 0 && (m_snap >> (4 * m_idx)) == 16'h0 && (m_dps >> m_idx) == 4'h0) bl = 1'b1;
`endif
      if (bl) e = {4'b1111, 7'h7F, 1'b1};
      else    e = {~(4'b0001 << m_idx), glyph(m_snap[4*m_idx +: 4]), ~m_dps[m_idx]};
      if (m_rcnt == RD - 1) begin
        if (m_idx == 3) begin m_snap = digits; m_dps = dp; end
        m_idx  = (m_idx + 1) % 4;
        m_rcnt = 0;
      end else m_rcnt++;
      if (m_bcnt == BD - 1) begin m_bcnt = 0; m_boff = ~m_boff; end
      else m_bcnt++;
    end
    sb_q.push_back(e);
  end

  always @(negedge clk) begin
    logic [11:0] e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("sb_an", {12'h0, an}, {12'h0, e[11:8]});
      check_eq("sb_seg", {9'h0, seg}, {9'h0, e[7:1]});
      check_eq("sb_dp_n", {15'h0, dp_n}, {15'h0, e[0]});
    end
  end

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_an"}, {12'h0, an}, 16'h000F);
    check_eq({tag, "_seg"}, {9'h0, seg}, 16'h007F);
    check_eq({tag, "_dp_n"}, {15'h0, dp_n}, 16'h0001);
  endtask

  // return at the first sample of a digit-0 slot
  task automatic wait_frame();
    logic [3:0] prev;
    bit found;
    prev  = an;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (an == 4'b1110 && prev != 4'b1110) found = 1'b1;
      prev = an;
    end
    if (!found) check_eq("frame_sync_timeout", 16'h0, 16'h1);
  endtask

  initial begin
    logic [3:0] dig_a [4];
    logic [3:0] dig_b [4];
    int c_off, c_d0, c_d2;
    dig_a = '{4'h4, 4'h3, 4'h2, 4'h1};
    dig_b = '{4'h8, 4'h7, 4'h6, 4'h5};

    rst = 1'b1; digits = 16'hFFFF; dp = 4'hF; adj_sel = 3'd0;
    repeat (3) begin
      @(negedge clk);
      check_reset_vals("rst_hold");
    end
    rst = 1'b0; digits = 16'h1234; dp = 4'h0; adj_sel = 3'd4;
    #1 check_reset_vals("rst_release");
    @(negedge clk);
    check_eq("first_an", {12'h0, an}, 16'h000E);
    check_eq("first_seg", {9'h0, seg}, {9'h0, 7'b1000000});

    // scan order, then a mid-frame digits change that must not tear the frame
    wait_frame();
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      check_eq("scan_an", {12'h0, an}, {12'h0, ~(4'b0001 << ((i / 4) % 4))});
      check_eq("scan_seg", {9'h0, seg},
               {9'h0, glyph(i < 16 ? dig_a[i / 4] : dig_b[(i - 16) / 4])});
      if (i == 4) digits = 16'h5678;
    end

    // blink on digit 2
    adj_sel = 3'd2;
    c_off = 0; c_d0 = 0; c_d2 = 0;
    repeat (128) begin
      @(negedge clk);
      if (an == 4'b1111) c_off++;
      if (an == 4'b1110) c_d0++;
      if (an == 4'b1011) c_d2++;
    end
    check_eq("blink_off_cycles", 16'(c_off), 16'd16);
    check_eq("blink_d2_cycles", 16'(c_d2), 16'd16);
    check_eq("blink_d0_cycles", 16'(c_d0), 16'd32);
    adj_sel = 3'd7;
    c_off = 0; c_d2 = 0;
    repeat (64) begin
      @(negedge clk);
      if (an == 4'b1111) c_off++;
      if (an == 4'b1011) c_d2++;
    end
    check_eq("noblink_off_cycles", 16'(c_off), 16'd0);
    check_eq("noblink_d2_cycles", 16'(c_d2), 16'd16);

    // decimal point and hex glyphs
    digits = 16'h00AF; dp = 4'b0010; adj_sel = 3'd4;
    repeat (20) @(negedge clk);
    wait_frame();
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 0) begin
        check_eq("hex_d0_seg", {9'h0, seg}, {9'h0, 7'b0001110});
        check_eq("hex_d0_dp", {15'h0, dp_n}, 16'h1);
      end else if (i == 4) begin
        check_eq("hex_d1_seg", {9'h0, seg}, {9'h0, 7'b0001000});
        check_eq("hex_d1_dp", {15'h0, dp_n}, 16'h0);
        check_eq("hex_d1_an", {12'h0, an}, 16'h000D);
      end else if (i == 8) begin
`ifdef SEG_LZ_BLANK_EN
        check_eq("hex_d2_an", {12'h0, an}, 16'h000F);
`else
        check_eq("hex_d2_an", {12'h0, an}, 16'h000B);
        check_eq("hex_d2_dp", {15'h0, dp_n}, 16'h1);
`endif
      end
    end

    // leading zeros
    digits = 16'h0005; dp = 4'h0;
    repeat (20) @(negedge clk);
    wait_frame();
    check_eq("lz_d0_seg", {9'h0, seg}, {9'h0, 7'b0010010});
    for (int k = 1; k < 4; k++) begin
      repeat (4) @(negedge clk);
`ifdef SEG_LZ_BLANK_EN
      check_eq("lz_an", {12'h0, an}, 16'h000F);
      check_eq("lz_seg", {9'h0, seg}, 16'h007F);
`else
      check_eq("lz_an", {12'h0, an}, {12'h0, ~(4'b0001 << k)});
      check_eq("lz_seg", {9'h0, seg}, {9'h0, 7'b1000000});
`endif
    end

    // reset in the middle of a frame
    digits = 16'h9876;
    wait_frame();
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    #1 check_reset_vals("midrst_release");
    @(negedge clk);
    check_eq("midrst_an", {12'h0, an}, 16'h000E);
    check_eq("midrst_seg", {9'h0, seg}, {9'h0, 7'b1000000});
    repeat (24) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
